// File: rtl/four_bank_mem.sv
// four_bank_mem
// Banked main-memory responder behind the cache controller. Accepts one word
// read or write per cycle, spread over four banks that each stay busy for
// BANK_BUSY cycles after an access. Read data appears two cycles after the
// acceptance edge through a two-stage pipeline (array read, then output).
module four_bank_mem #(
    parameter int WORDS_PER_BANK = 8192,
    parameter int BANK_BUSY      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int         WORD_W    = $clog2(WORDS_PER_BANK);
    localparam logic [2:0] BUSY_LOAD = 3'(BANK_BUSY - 1);

    // Request decode
    logic [1:0]        w_bank;
    logic [WORD_W-1:0] w_word;
    logic              w_req;
    logic              w_illegal;
    logic              w_conflict;
    logic              w_accept;
    logic              w_wr_accept;
    logic              w_rd_accept;

    // Bank occupancy
    logic [2:0]        r_cnt [4];
    logic [3:0]        r_busy;

    // Storage
    logic [15:0]       r_mem [4][WORDS_PER_BANK];

    // Read pipeline: p0 holds the accepted address, s1 the array output
    logic              r_p0_valid;
    logic [1:0]        r_p0_bank;
    logic [WORD_W-1:0] r_p0_word;
    logic              r_s1_valid;
    logic [15:0]       r_s1_data;
    logic              r_data_valid;
    logic [15:0]       r_data_out;

    // Classify the current request: illegal, blocked by a busy bank, or accepted.
    // NOTE: combinational logic uses blocking '=' and assigns every output on every pass, so no latch can form.
    always_comb begin
        w_bank      = addr[2:1];
        w_word      = addr[3 +: WORD_W];
        w_req       = rd | wr;
        w_illegal   = w_req & ((rd & wr) | addr[0]);
        w_conflict  = w_req & ~w_illegal & r_busy[w_bank];
        w_accept    = w_req & ~w_illegal & ~r_busy[w_bank];
        w_wr_accept = w_accept & wr;
        w_rd_accept = w_accept & rd;
    end

    assign err        = w_illegal;
    assign stall      = w_conflict;
    assign busy       = r_busy;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

    // Per-bank occupancy counters: reload on acceptance, otherwise count down and hold at zero.
    // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= 3'd0;
            end
            r_busy <= 4'b0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt[b]  <= BUSY_LOAD;
                    r_busy[b] <= 1'b1;
                end else if (r_cnt[b] != 3'd0) begin
                    r_cnt[b]  <= r_cnt[b] - 3'd1;
                    r_busy[b] <= (r_cnt[b] != 3'd1);
                end else begin
                    r_busy[b] <= 1'b0;
                end
            end
        end
    end

    // Storage array: write on an accepted write, read the word held in pipeline stage p0.
    // NOTE: the array is deliberately left out of reset; contents survive reset and a RAM macro cannot be cleared in one edge.
    always_ff @(posedge clk) begin
        if (rst && w_wr_accept) begin
            r_mem[w_bank][w_word] <= data_in;
        end
        r_s1_data <= r_mem[r_p0_bank][r_p0_word];
    end

    // Read pipeline control: capture accepted read address, then valid flags and output data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p0_valid   <= 1'b0;
            r_p0_bank    <= 2'd0;
            r_p0_word    <= '0;
            r_s1_valid   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= 16'h0000;
        end else begin
            r_p0_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_p0_bank <= w_bank;
                r_p0_word <= w_word;
            end
            r_s1_valid   <= r_p0_valid;
            r_data_valid <= r_s1_valid;
            r_data_out   <= r_s1_valid ? r_s1_data : 16'h0000;
        end
    end

endmodule

// File: tb/tb_four_bank_mem.sv
// Testbench for four_bank_mem: a table of directed vectors with explicit
// expected outputs, followed by randomized traffic checked against a
// behavioural model (word-addressed memory, per-bank free time, response queue).
module tb_four_bank_mem;

    localparam int BB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    four_bank_mem #(.WORDS_PER_BANK(8192), .BANK_BUSY(BB)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- counters and check ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    logic [15:0] mdl_mem [int];
    int          written_q [$];
    int          free_edge [4];
    int          edge_n = 0;
    rsp_t        rsp_q [$];

    logic        mdl_err, mdl_stall, mdl_valid;
    logic [3:0]  mdl_busy;
    logic [15:0] mdl_data;
    logic        act_err, act_stall, act_valid;
    logic [3:0]  act_busy;
    logic [15:0] act_data;

    // One clock cycle: apply inputs, sample combinational outputs, clock, sample registered outputs.
    task automatic step(input logic rn, input logic rdv, input logic wrv,
                        input logic [15:0] a, input logic [15:0] d);
        logic       req, ill, acc;
        logic [1:0] bk;
        int         key;
        rst = rn; rd = rdv; wr = wrv; addr = a; data_in = d;
        #2;
        act_err   = err;
        act_stall = stall;
        req = rdv | wrv;
        ill = req && ((rdv && wrv) || a[0]);
        bk  = a[2:1];
        key = int'(a[15:1]);
        mdl_err   = ill;
        mdl_stall = req && !ill && (edge_n < free_edge[bk]);
        acc       = req && !ill && !mdl_stall;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            for (int b = 0; b < 4; b++) free_edge[b] = 0;
            rsp_q.delete();
        end else if (acc) begin
            free_edge[bk] = edge_n + BB - 1;
            if (wrv) begin
                if (!mdl_mem.exists(key)) written_q.push_back(key);
                mdl_mem[key] = d;
            end else begin
                rsp_q.push_back('{due: edge_n + 2, data: mdl_mem[key]});
            end
        end
        mdl_valid = 1'b0;
        mdl_data  = 16'h0000;
        if (rsp_q.size() > 0 && rsp_q[0].due == edge_n) begin
            mdl_valid = 1'b1;
            mdl_data  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        for (int b = 0; b < 4; b++) mdl_busy[b] = (edge_n < free_edge[b]);
        #1;
        act_busy  = busy;
        act_valid = data_valid;
        act_data  = data_out;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rn;
        logic        rdv;
        logic        wrv;
        logic [15:0] a;
        logic [15:0] d;
        logic        e_err;
        logic        e_stall;
        logic [3:0]  e_busy;
        logic        e_valid;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic rn, input logic rdv, input logic wrv, input logic [15:0] a,
                       input logic [15:0] d, input logic e, input logic s, input logic [3:0] b,
                       input logic v, input logic [15:0] q);
        tbl.push_back('{rn, rdv, wrv, a, d, e, s, b, v, q});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rdat;
        logic        rrn, rrd, rwr;
        int          op;

        //   rn rd wr addr      data      err stl busy     vld dout
        // writeback burst then read burst
        add(1, 0, 1, 16'h1230, 16'hA0A0, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 1, 16'h1232, 16'hA1A1, 0, 0, 4'b0011, 0, 16'h0000);
        add(1, 0, 1, 16'h1234, 16'hA2A2, 0, 0, 4'b0111, 0, 16'h0000);
        add(1, 0, 1, 16'h1236, 16'hA3A3, 0, 0, 4'b1110, 0, 16'h0000);
        add(1, 1, 0, 16'h1230, 16'h0000, 0, 0, 4'b1101, 0, 16'h0000);
        add(1, 1, 0, 16'h1232, 16'h0000, 0, 0, 4'b1011, 0, 16'h0000);
        add(1, 1, 0, 16'h1234, 16'h0000, 0, 0, 4'b0111, 1, 16'hA0A0);
        add(1, 1, 0, 16'h1236, 16'h0000, 0, 0, 4'b1110, 1, 16'hA1A1);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1100, 1, 16'hA2A2);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1000, 1, 16'hA3A3);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        // bank conflict: second write to bank 0 held until accepted
        add(1, 0, 1, 16'h0000, 16'h1111, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 1, 16'h0008, 16'h2222, 0, 1, 4'b0001, 0, 16'h0000);
        add(1, 0, 1, 16'h0008, 16'h2222, 0, 1, 4'b0001, 0, 16'h0000);
        add(1, 0, 1, 16'h0008, 16'h2222, 0, 1, 4'b0000, 0, 16'h0000);
        add(1, 0, 1, 16'h0008, 16'h2222, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        // illegal requests leave contents and busy untouched
        add(1, 0, 1, 16'h0002, 16'h3333, 0, 0, 4'b0010, 0, 16'h0000);
        add(1, 1, 1, 16'h0002, 16'hFFFF, 1, 0, 4'b0010, 0, 16'h0000);
        add(1, 1, 0, 16'h0003, 16'h0000, 1, 0, 4'b0010, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        add(1, 1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0010, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0010, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0010, 1, 16'h3333);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        // read after write, same word
        add(1, 0, 1, 16'h4440, 16'h5555, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        add(1, 1, 0, 16'h4440, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 1, 16'h5555);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        // address wrap: top word of bank 3, then word 0 of bank 0
        add(1, 0, 1, 16'hFFFE, 16'hBEEF, 0, 0, 4'b1000, 0, 16'h0000);
        add(1, 0, 1, 16'h0000, 16'hCAFE, 0, 0, 4'b1001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 1, 0, 16'hFFFE, 16'h0000, 0, 0, 4'b1000, 0, 16'h0000);
        add(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 4'b1001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1001, 1, 16'hBEEF);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 1, 16'hCAFE);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        // reset right after an accepted read discards it
        add(1, 1, 0, 16'h1230, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        add(1, 1, 0, 16'h1230, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 1, 16'hA0A0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);
        // a write presented on a reset edge is not performed
        add(0, 0, 1, 16'h1232, 16'h9999, 0, 0, 4'b0000, 0, 16'h0000);
        add(1, 1, 0, 16'h1232, 16'h0000, 0, 0, 4'b0010, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0010, 0, 16'h0000);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0010, 1, 16'hA1A1);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000);

        for (int b = 0; b < 4; b++) free_edge[b] = 0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("reset busy",       {12'h000, act_busy}, 16'h0000);
        check("reset data_valid", {15'h0, act_valid},  16'h0000);
        check("reset data_out",   act_data,            16'h0000);
        check("reset err",        {15'h0, act_err},    16'h0000);
        check("reset stall",      {15'h0, act_stall},  16'h0000);

        // Directed table
        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].rdv, tbl[i].wrv, tbl[i].a, tbl[i].d);
            check($sformatf("v%0d err", i),   {15'h0, act_err},    {15'h0, tbl[i].e_err});
            check($sformatf("v%0d stall", i), {15'h0, act_stall},  {15'h0, tbl[i].e_stall});
            check($sformatf("v%0d busy", i),  {12'h000, act_busy}, {12'h000, tbl[i].e_busy});
            check($sformatf("v%0d valid", i), {15'h0, act_valid},  {15'h0, tbl[i].e_valid});
            check($sformatf("v%0d dout", i),  act_data,            tbl[i].e_data);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            op   = int'($urandom_range(0, 15));
            rrn  = ($urandom_range(0, 63) != 0);
            rrd  = 1'b0;
            rwr  = 1'b0;
            rdat = 16'($urandom);
            ra   = 16'(written_q[$urandom_range(0, written_q.size() - 1)] << 1);
            if (op >= 4 && op <= 8) begin
                rwr = 1'b1;
                if ($urandom_range(0, 3) == 0) ra = 16'($urandom) & 16'hFFFE;
            end else if (op >= 9 && op <= 13) begin
                rrd = 1'b1;
            end else if (op == 14) begin
                rrd = 1'b1;
                rwr = 1'b1;
            end else if (op == 15) begin
                rrd = $urandom_range(0, 1) == 1;
                rwr = ~rrd;
                ra  = ra | 16'h0001;
            end
            step(rrn, rrd, rwr, ra, rdat);
            check($sformatf("r%0d err", n),   {15'h0, act_err},    {15'h0, mdl_err});
            check($sformatf("r%0d stall", n), {15'h0, act_stall},  {15'h0, mdl_stall});
            check($sformatf("r%0d busy", n),  {12'h000, act_busy}, {12'h000, mdl_busy});
            check($sformatf("r%0d valid", n), {15'h0, act_valid},  {15'h0, mdl_valid});
            check($sformatf("r%0d dout", n),  act_data,            mdl_data);
        end

        // Drain outstanding reads
        for (int n = 0; n < 6; n++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            check($sformatf("drain%0d busy", n),  {12'h000, act_busy}, {12'h000, mdl_busy});
            check($sformatf("drain%0d valid", n), {15'h0, act_valid},  {15'h0, mdl_valid});
            check($sformatf("drain%0d dout", n),  act_data,            mdl_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
